// File: rtl/trail_grid.sv
// trail_grid: cell-level trail memory and collision checker for the
// light-cycle game, with an independent read port for the VGA colour mux.
module trail_grid #(
    parameter int GRID_W = 80,
    parameter int GRID_H = 60,
    parameter int ADDR_W = 13
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        clear,
    input  logic        mv_valid,
    output logic        mv_ready,
    input  logic        mv_player,
    input  logic [6:0]  mv_x,
    input  logic [5:0]  mv_y,
    output logic        hit_valid,
    output logic        hit,
    output logic        hit_player,
    output logic        busy,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [1:0]  pix_cell
);

    localparam int CELLS = GRID_W * GRID_H;

    typedef enum logic [2:0] {CLEAR, IDLE, RD, CHK, RESP} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pend_q;
    logic              player_q;
    logic              oob_q;
    logic              rdy_q;
    logic              busy_q;
    logic              hv_q;
    logic              hit_q;
    logic              hp_q;
    logic [1:0]        rdata_q;
    logic [1:0]        pix_q;

    logic [1:0]        mem [CELLS];

    logic [ADDR_W-1:0] mv_addr_d;
    logic              oob_d;
    logic [ADDR_W-1:0] addr_a;
    logic              we_a;
    logic [1:0]        wdata_a;
    logic              pix_in;
    logic [ADDR_W-1:0] pix_addr;

    // Move address decode and off-grid detection for the incoming request
    always_comb begin
        mv_addr_d = ADDR_W'(mv_y) * ADDR_W'(GRID_W) + ADDR_W'(mv_x);
        oob_d     = (mv_x >= 7'(GRID_W)) || (mv_y >= 6'(GRID_H));
    end

    // Port A control: CLEAR sweep owns the port, otherwise the latched move;
    // writes are suppressed while reset is high so a move cut off in CHK leaves no trace
    always_comb begin
        addr_a  = (state_q == CLEAR) ? clr_addr_q : addr_q;
        wdata_a = (state_q == CLEAR) ? 2'd0 : (player_q ? 2'd2 : 2'd1);
        we_a    = !reset && ((state_q == CLEAR) ||
                             ((state_q == CHK) && !oob_q && (rdata_q == 2'd0)));
    end

    // Display port address decode; pixels outside 640x480 map to empty
    always_comb begin
        pix_in   = (pix_x < 10'(GRID_W * 8)) && (pix_y < 10'(GRID_H * 8));
        pix_addr = ADDR_W'(pix_y[8:3]) * ADDR_W'(GRID_W) + ADDR_W'(pix_x[9:3]);
    end

    // Port A: synchronous read-before-write RAM access
    always_ff @(posedge CLOCK_50) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        rdata_q <= mem[addr_a];
    end

    // Port B: registered display read; same-cycle port A write returns old data
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pix_q <= 2'd0;
        end else if (pix_in) begin
            pix_q <= mem[pix_addr];
        end else begin
            pix_q <= 2'd0;
        end
    end

    // Control FSM: clear sweep, move handshake, read, check/write, respond.
    // mv_ready is registered, so it is precomputed from the pending flag the
    // FSM will see in the following IDLE cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            addr_q     <= '0;
            pend_q     <= 1'b0;
            player_q   <= 1'b0;
            oob_q      <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b1;
            hv_q       <= 1'b0;
            hit_q      <= 1'b0;
            hp_q       <= 1'b0;
        end else begin
            hv_q   <= 1'b0;
            pend_q <= pend_q | clear;
            case (state_q)
                CLEAR: begin
                    if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
                        state_q    <= IDLE;
                        clr_addr_q <= '0;
                        pend_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        rdy_q      <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (pend_q) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end else if (mv_valid && rdy_q) begin
                        state_q  <= RD;
                        player_q <= mv_player;
                        oob_q    <= oob_d;
                        addr_q   <= oob_d ? '0 : mv_addr_d;
                        rdy_q    <= 1'b0;
                    end else begin
                        rdy_q <= !clear;
                    end
                end
                RD: begin
                    state_q <= CHK;
                end
                CHK: begin
                    hit_q   <= oob_q || (rdata_q != 2'd0);
                    hp_q    <= player_q;
                    hv_q    <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                    rdy_q   <= !(pend_q | clear);
                end
                default: begin
                    state_q    <= CLEAR;
                    clr_addr_q <= '0;
                    busy_q     <= 1'b1;
                    rdy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mv_ready   = rdy_q;
    assign busy       = busy_q;
    assign hit_valid  = hv_q;
    assign hit        = hit_q;
    assign hit_player = hp_q;
    assign pix_cell   = pix_q;

endmodule
